// File: rtl/cache_mem_master.sv
// Cache-side memory initiator: turns one line fill or writeback into LINEWORDS word RD/WT cycles.
// Optional macro CRITICAL_WORD_FIRST_EN: fills start at the requested word and wrap within the line.
module cache_mem_master #(
    parameter int ADDRESSBIT = 16,
    parameter int WORDSIZE   = 32,
    parameter int LINEWORDS  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_req_valid,
    output logic                          o_req_ready,
    input  logic                          i_req_wb,
    input  logic [ADDRESSBIT-1:0]         i_req_addr,
    output logic [$clog2(LINEWORDS)-1:0]  o_wb_idx,
    input  logic [WORDSIZE-1:0]           i_wb_data,
    output logic                          o_fill_valid,
    output logic [$clog2(LINEWORDS)-1:0]  o_fill_idx,
    output logic [WORDSIZE-1:0]           o_fill_data,
    output logic                          o_done,
    output logic [ADDRESSBIT-1:0]         o_mem_addr,
    output logic [WORDSIZE-1:0]           o_mem_wdata,
    input  logic [WORDSIZE-1:0]           i_mem_rdata,
    output logic                          o_mem_rdwt
);
    localparam int OFF = $clog2(LINEWORDS);

    typedef enum logic [2:0] {IDLE, WB, FILL, DRAIN, DONE} state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [ADDRESSBIT-OFF-1:0] r_tag;
    logic [OFF-1:0]            r_s;
    logic [OFF-1:0]            r_n;
    logic                      r_fill_valid;
    logic [OFF-1:0]            r_fill_idx;
    logic [OFF-1:0]            w_idx;
    logic [OFF-1:0]            w_start;
    logic                      w_last;
    logic                      w_accept;
    logic [ADDRESSBIT-1:0]     w_line_addr;

    // Index wraps naturally in OFF bits, so the address never carries out of the line.
    assign w_idx       = r_s + r_n;
    assign w_last      = (r_n == OFF'(LINEWORDS - 1));
    assign w_accept    = (r_state == IDLE) && i_req_valid;
    assign w_line_addr = {r_tag, w_idx};

`ifdef CRITICAL_WORD_FIRST_EN
    assign w_start = i_req_wb ? '0 : i_req_addr[OFF-1:0];
`else
    logic w_unused_offset;
    assign w_unused_offset = ^i_req_addr[OFF-1:0];
    assign w_start         = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_req_ready  = 1'b0;
        o_mem_rdwt   = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_wb_idx     = '0;
        o_done       = 1'b0;
        unique case (r_state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_state_next = i_req_wb ? WB : FILL;
                end
            end
            WB: begin
                o_mem_rdwt  = 1'b1;
                o_mem_addr  = w_line_addr;
                o_mem_wdata = i_wb_data;
                o_wb_idx    = w_idx;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            FILL: begin
                o_mem_addr = w_line_addr;
                if (w_last) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                w_state_next = DONE;
            end
            DONE: begin
                o_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Read data returns one cycle after each FILL issue, tagged with that issue's index.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tag        <= '0;
            r_s          <= '0;
            r_n          <= '0;
            r_fill_valid <= 1'b0;
            r_fill_idx   <= '0;
        end else begin
            r_fill_valid <= (r_state == FILL);
            r_fill_idx   <= (r_state == FILL) ? w_idx : '0;
            if (w_accept) begin
                r_tag <= i_req_addr[ADDRESSBIT-1:OFF];
                r_s   <= w_start;
                r_n   <= '0;
            end else if ((r_state == WB) || (r_state == FILL)) begin
                r_n <= r_n + OFF'(1);
            end
        end
    end

    assign o_fill_valid = r_fill_valid;
    assign o_fill_idx   = r_fill_idx;
    assign o_fill_data  = r_fill_valid ? i_mem_rdata : '0;

endmodule
